// File: rtl/data_mem_responder.sv
// Data-side memory responder for the pipelined MIPS core.
// A word-addressed RAM and a small MMIO block (timer with interrupt, LED
// register) sit behind a MemRead/MemWrite/Ready handshake. Ready is asserted
// after a fixed number of wait states.
module data_mem_responder #(
  parameter int RAM_WORDS   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemAddress,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        Ready,
  output logic        Irq,
  output logic [7:0]  LED
);
  localparam int IDX_W = $clog2(RAM_WORDS);
  // Value of the wait counter on the last WAIT cycle.
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               mmio_q, mmio_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        th_q, th_d;
  logic [31:0]        tl_q, tl_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic               st_q, st_d;
  logic               irq_q, irq_d;
  logic [7:0]         led_q, led_d;

  logic [31:0]        ram [RAM_WORDS];

  logic               req;
  logic               ready_c;
  logic               commit;
  logic               load_now;
  logic               ovf;
  logic [31:0]        rd_val;
  logic               unused_addr_bits;

  // Address bits that neither the RAM index nor the MMIO decode look at.
  assign unused_addr_bits = ^{MemAddress[27:IDX_W+2], MemAddress[1:0]};
  assign req = MemRead | MemWrite;

  // FSM state register; reset aborts any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT: if (cnt_q == WAIT_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: Ready is decoded from state so reset drops it at once;
  // stores commit on the edge that ends DONE.
  always_comb begin
    ready_c = (state_q == S_DONE);
    commit  = ready_c & wr_q;
  end

  assign Ready     = ready_c;
  assign Read_data = rdata_q;
  assign Irq       = irq_q;
  assign LED       = led_q;

  // Request capture and wait-state counter. A simultaneous read and write is
  // treated as a store only.
  always_comb begin
    mmio_d  = mmio_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (state_q == S_IDLE && req) begin
      mmio_d  = (MemAddress[31:28] == 4'h4);
      idx_d   = MemAddress[IDX_W+1:2];
      off_d   = MemAddress[3:2];
      wdata_d = Write_data;
      wr_d    = MemWrite;
      rd_d    = MemRead & ~MemWrite;
    end
    cnt_d = (state_q == S_WAIT) ? cnt_q + 4'd1 : 4'd0;
  end

  // Load path: sample RAM or MMIO on the edge that enters DONE. The _d fields
  // are used so a zero-wait request reads straight from the inputs.
  always_comb begin
    rd_val = 32'd0;
    if (mmio_d) begin
      case (off_d)
        2'd0:    rd_val = th_q;
        2'd1:    rd_val = tl_q;
        2'd2:    rd_val = {29'd0, st_q, ie_q, en_q};
        default: rd_val = {24'd0, led_q};
      endcase
    end else begin
      rd_val = ram[idx_d];
    end
    load_now = (state_d == S_DONE) && (state_q != S_DONE) && rd_d;
    rdata_d  = load_now ? rd_val : rdata_q;
  end

  // Timer and MMIO registers. A CPU store to TL beats the increment/reload;
  // an overflow beats a CPU store clearing the status bit.
  always_comb begin
    th_d  = th_q;
    en_d  = en_q;
    ie_d  = ie_q;
    led_d = led_q;
    ovf   = en_q && (tl_q == 32'hFFFF_FFFF);
    if (ovf)       tl_d = th_q;
    else if (en_q) tl_d = tl_q + 32'd1;
    else           tl_d = tl_q;
    st_d = st_q | ovf;
    if (commit && mmio_q) begin
      case (off_q)
        2'd0: th_d = wdata_q;
        2'd1: tl_d = wdata_q;
        2'd2: begin
          en_d = wdata_q[0];
          ie_d = wdata_q[1];
          st_d = wdata_q[2] | ovf;
        end
        default: led_d = wdata_q[7:0];
      endcase
    end
    irq_d = ie_d & st_d;
  end

  // Datapath and MMIO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      mmio_q  <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= 32'd0;
      th_q    <= 32'd0;
      tl_q    <= 32'd0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      st_q    <= 1'b0;
      irq_q   <= 1'b0;
      led_q   <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      mmio_q  <= mmio_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      th_q    <= th_d;
      tl_q    <= tl_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      st_q    <= st_d;
      irq_q   <= irq_d;
      led_q   <= led_d;
    end
  end

  // Data RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && !mmio_q) ram[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic on a
// two-wait-state instance, checked by a scoreboard fed from a behavioural
// model, and a short directed sequence on a zero-wait instance.
module tb_data_mem_responder;
  localparam int RW = 256;
  localparam int W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mr, mw;
  logic [31:0] ma, wd, rdata;
  logic        rdy, irq;
  logic [7:0]  led;

  logic        z_rst, z_mr, z_mw;
  logic [31:0] z_ma, z_wd, z_rdata;
  logic        z_rdy, z_irq;
  logic [7:0]  z_led;

  data_mem_responder #(.RAM_WORDS(RW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .MemRead(mr), .MemWrite(mw), .MemAddress(ma),
    .Write_data(wd), .Read_data(rdata), .Ready(rdy), .Irq(irq), .LED(led));

  data_mem_responder #(.RAM_WORDS(RW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(z_rst), .MemRead(z_mr), .MemWrite(z_mw), .MemAddress(z_ma),
    .Write_data(z_wd), .Read_data(z_rdata), .Ready(z_rdy), .Irq(z_irq), .LED(z_led));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_on = 0;

  typedef struct { int cyc; logic [31:0] rd; bit chk; } exp_t;
  exp_t q[$];

  // Reference model state
  logic [31:0] m_ram [RW];
  bit          m_known [RW];
  logic [31:0] m_th, m_tl, m_last;
  bit          m_last_k, m_en, m_ie, m_st;
  logic [7:0]  m_led;

  // Transaction in flight
  int          sample_at = -1;
  int          commit_at = -1;
  bit          p_rd, p_wr;
  logic [31:0] p_addr, p_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_en = 0; m_ie = 0; m_st = 0; m_led = 0;
    m_last = 0; m_last_k = 1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % RW);
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit k);
    k = 1;
    v = 0;
    if (a[31:28] == 4'h4) begin
      case (a[3:2])
        2'd0:    v = m_th;
        2'd1:    v = m_tl;
        2'd2:    v = {29'd0, m_st, m_ie, m_en};
        default: v = {24'd0, m_led};
      endcase
    end else begin
      v = m_ram[widx(a)];
      k = m_known[widx(a)];
    end
  endtask

  // One clock edge of the model: sample a load, run the timer, apply a store.
  task automatic tick();
    exp_t        e;
    logic [31:0] v;
    bit          k, ovf;
    @(posedge clk);
    cyc++;
    if (cyc == sample_at) begin
      e.cyc = cyc;
      if (p_rd && !p_wr) begin
        model_read(p_addr, v, k);
        m_last = v; m_last_k = k;
      end
      e.rd = m_last; e.chk = m_last_k;
      q.push_back(e);
    end
    ovf = m_en && (m_tl == 32'hFFFF_FFFF);
    if (ovf) m_tl = m_th;
    else if (m_en) m_tl = m_tl + 1;
    if (ovf) m_st = 1;
    if (cyc == commit_at && p_wr) begin
      if (p_addr[31:28] == 4'h4) begin
        case (p_addr[3:2])
          2'd0: m_th = p_data;
          2'd1: m_tl = p_data;
          2'd2: begin m_en = p_data[0]; m_ie = p_data[1]; m_st = p_data[2] | ovf; end
          default: m_led = p_data[7:0];
        endcase
      end else begin
        m_ram[widx(p_addr)] = p_data;
        m_known[widx(p_addr)] = 1;
      end
    end
    #1;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    mr = rd; mw = wr; ma = a; wd = d;
    p_rd = rd; p_wr = wr; p_addr = a; p_data = d;
    sample_at = cyc + 1 + W;
    commit_at = cyc + 2 + W;
    tick();
    mr = 0; mw = 0; ma = $urandom; wd = $urandom;
    while (cyc < commit_at) tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(3) == 0) a[31:28] = 4'h4;
    else begin
      if (a[31:28] == 4'h4) a[31:28] = 4'h0;
      a[9:2] = 8'($urandom_range(15));
    end
    return a;
  endfunction

  // Monitor: every cycle compare Ready/Read_data against the scoreboard and
  // LED/Irq against the model.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (rdy) begin
        if (q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ready: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("ready_cycle", cyc, e.cyc);
          if (e.chk) chk("read_data", rdata, e.rd);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        n_vec++; n_bad++;
        $display("FAIL missing_ready: got 0, expected 1 (cycle %0d)", cyc);
        void'(q.pop_front());
      end
      chk("led", {24'd0, led}, {24'd0, m_led});
      chk("irq", {31'd0, irq}, {31'd0, (m_ie & m_st)});
    end
  end

  initial begin
    reset = 1; mr = 0; mw = 0; ma = 0; wd = 0;
    z_rst = 1; z_mr = 0; z_mw = 0; z_ma = 0; z_wd = 0;
    model_reset();
    tick(); tick();
    chk("reset_read_data", rdata, 32'd0);
    chk("reset_ready", {31'd0, rdy}, 32'd0);
    chk("reset_led", {24'd0, led}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset = 0; z_rst = 0;
    mon_on = 1;
    tick();
    fork
      begin : main_seq
        // store then load, back to back
        txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        txn(1, 0, 32'h0000_0010, 32'h0);
        // aliasing
        txn(0, 1, 32'h0000_0404, 32'h1234_5678);
        txn(1, 0, 32'h0000_0004, 32'h0);
        // timer overflow and interrupt
        txn(0, 1, 32'h4000_0000, 32'hFFFF_FFF0);
        txn(0, 1, 32'h4000_0004, 32'hFFFF_FFFD);
        txn(0, 1, 32'h4000_0008, 32'h3);
        repeat (4) tick();
        chk("irq_after_ovf", {31'd0, irq}, 32'd1);
        txn(1, 0, 32'h4000_0004, 32'h0);
        txn(0, 1, 32'h4000_0008, 32'h3);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        // clear racing an overflow: overflow wins
        txn(0, 1, 32'h4000_0008, 32'h0);
        txn(0, 1, 32'h4000_0000, 32'h0000_0005);
        txn(0, 1, 32'h4000_0004, 32'hFFFF_FFFC);
        txn(0, 1, 32'h4000_0008, 32'h1);
        txn(0, 1, 32'h4000_0008, 32'h3);
        txn(1, 0, 32'h4000_0008, 32'h0);
        txn(0, 1, 32'h4000_0004, 32'h0000_1234);
        txn(1, 0, 32'h4000_0004, 32'h0);
        txn(0, 1, 32'h4000_0008, 32'h0);
        // LED and aliased MMIO offset
        txn(0, 1, 32'h4000_000C, 32'h0000_01A5);
        txn(1, 0, 32'h4000_000C, 32'h0);
        chk("led_value", {24'd0, led}, 32'h0000_00A5);
        txn(0, 1, 32'h4000_0010, 32'h0000_0077);
        txn(1, 0, 32'h4000_0000, 32'h0);
        // reset during WAIT aborts the store
        txn(0, 1, 32'h0000_0020, 32'h0000_CAFE);
        mw = 1; ma = 32'h20; wd = 32'h55;
        p_rd = 0; p_wr = 1; p_addr = 32'h20; p_data = 32'h55;
        sample_at = cyc + 1 + W; commit_at = cyc + 2 + W;
        tick();
        mw = 0;
        tick();
        reset = 1;
        model_reset();
        sample_at = -1; commit_at = -1;
        tick(); tick();
        reset = 0;
        tick();
        txn(1, 0, 32'h0000_0020, 32'h0);
        // simultaneous read and write is a store
        txn(1, 0, 32'h0000_0010, 32'h0);
        txn(1, 1, 32'h0000_0008, 32'h0000_0099);
        txn(1, 0, 32'h0000_0008, 32'h0);
        // fill a window of RAM, then random traffic
        for (int i = 0; i < 16; i++) txn(0, 1, 32'(i * 4), $urandom);
        for (int i = 0; i < 150; i++) begin
          int kind;
          kind = $urandom_range(2);
          repeat ($urandom_range(2)) tick();
          txn(kind != 1, kind != 0, rand_addr(), $urandom);
        end
        repeat (4) tick();
        chk("scoreboard_drained", q.size(), 32'd0);
      end
      begin : zero_wait_seq
        @(posedge clk); #1;
        z_mw = 1; z_ma = 32'h0000_0404; z_wd = 32'h1234_5678;
        @(posedge clk); #1;
        chk("w0_store_ready", {31'd0, z_rdy}, 32'd1);
        z_mw = 0;
        @(posedge clk); #1;
        chk("w0_idle_ready", {31'd0, z_rdy}, 32'd0);
        z_mr = 1; z_ma = 32'h0000_0004;
        @(posedge clk); #1;
        chk("w0_load_ready", {31'd0, z_rdy}, 32'd1);
        chk("w0_load_data", z_rdata, 32'h1234_5678);
        z_mr = 0;
        @(posedge clk); #1;
        chk("w0_no_double_ready", {31'd0, z_rdy}, 32'd0);
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
